// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared FSM state type and counter-width helper for the FIFO read streamer
package fifo_rd_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  function automatic int cnt_width(input int burst_len);
    return (burst_len > 2) ? $clog2(burst_len) : 1;
  endfunction
endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: two-entry in-order buffer with simultaneous push/pop
// Ports: clk, rst_n (async active-low); push/din write the tail; pop drops the head;
//        dout is the head entry; occ is the entry count (0..2).
module skid_buf2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            occ
);
  logic [DATA_WIDTH-1:0] e0, e1;
  assign dout = e0;
  // With a pop, the head is refilled from e1 if it exists, otherwise from din when pushing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      occ <= 2'd0;
    end else begin
      if (pop) e0 <= (occ == 2'd2) ? e1 : (push ? din : e0);
      else if (push && occ == 2'd0) e0 <= din;
      if (push && (pop ? occ == 2'd2 : occ == 2'd1)) e1 <= din;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end
  // The read throttle upstream keeps a third beat from ever arriving.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && occ == 2'd2));
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a registered-output FIFO into a valid/ready stream in fixed bursts
// Ports: clk, rst_n (async active-low); en requests draining; fifo_empty/fifo_rd_en/fifo_rd_data
//        talk to the FIFO read side (data valid one cycle after the strobe); m_valid/m_ready/
//        m_data/m_last form the output stream; busy flags any activity or pending data.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);
  localparam int CW = cnt_width(BURST_LEN);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
  state_t        state;
  logic          inflight, pop, issue_ok;
  logic [1:0]    occ;
  logic [2:0]    level;
  logic [CW-1:0] out_cnt, iss_cnt;
  skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .push (inflight),
    .din  (fifo_rd_data),
    .pop  (pop),
    .dout (m_data),
    .occ  (occ)
  );
  assign m_valid  = occ != 2'd0;
  assign pop      = m_valid && m_ready;
  assign issue_ok = state == RUN || state == FINISH;
  // Slots already committed after this cycle's pop; a new read only fits if fewer than two.
  assign level      = {1'b0, occ} + 3'(inflight) - 3'(pop);
  assign fifo_rd_en = issue_ok && !fifo_empty && level < 3'd2;
  assign m_last     = m_valid && out_cnt == LAST;
  assign busy       = state != IDLE || inflight || m_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      inflight <= 1'b0;
      out_cnt  <= '0;
      iss_cnt  <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) out_cnt <= out_cnt + 1'b1;
      if (fifo_rd_en) iss_cnt <= iss_cnt + 1'b1;
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= (iss_cnt == '0) ? IDLE : FINISH;
        FINISH:  if (fifo_rd_en && iss_cnt == LAST) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench with a FIFO model for the burst read streamer
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int MASK = 16383;
  logic          clk = 1'b0;
  logic          rst_n, en, fifo_empty, fifo_rd_en, m_valid, m_ready, m_last, busy;
  logic [DW-1:0] fifo_rd_data = '0;
  logic [DW-1:0] m_data;
  logic [DW-1:0] mem [0:MASK];
  int            wr_ptr = 0, rd_ptr = 0;
  logic          hold_empty = 1'b0;
  logic [DW:0]   exp_q [$];
  int            iss_idx = 0;
  int            n_cmp = 0, n_bad = 0;
  int            cyc = 0, pop_cnt = 0, rd_cnt = 0, last_cnt = 0;
  int            first_rd = -1, first_valid = -1, first_pop = -1, last_pop = -1;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;
  assign fifo_empty = hold_empty || (wr_ptr == rd_ptr);

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wr_ptr & MASK] = d;
    wr_ptr++;
  endtask

  // FIFO model: a strobe seen at the edge returns the word one cycle later; the expected
  // beat is queued at issue, its last flag set for every BL-th beat since reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      iss_idx = 0;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr & MASK];
      exp_q.push_back({(iss_idx % BL) == BL - 1, mem[rd_ptr & MASK]});
      iss_idx++;
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    logic [DW:0] e;
    cyc++;
    if (rst_n) begin
      if (stall_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, held_data);
        chk("stall_last", m_last, held_last);
      end
      if (fifo_rd_en && fifo_empty) chk("read_while_empty", fifo_rd_en, 0);
      if (fifo_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", m_data, 32'hdead);
        else begin
          e = exp_q.pop_front();
          chk("beat_data", m_data, e[DW-1:0]);
          chk("beat_last", m_last, e[DW]);
        end
        pop_cnt++;
        if (m_last) last_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      stall_prev = m_valid && !m_ready;
      held_data  = m_data;
      held_last  = m_last;
    end else stall_prev = 1'b0;
  end

  task automatic clr_stats();
    pop_cnt = 0; rd_cnt = 0; last_cnt = 0;
    first_rd = -1; first_valid = -1; first_pop = -1; last_pop = -1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    en = 1'b0;
    m_ready = 1'b0;
    hold_empty = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clr_stats();
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int i = 0; i < budget && pop_cnt < n; i++) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clr_stats();

    // full-rate drain of 8 words, bursts of 4
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    en = 1'b1; m_ready = 1'b1;
    wait_pops(8, 100);
    chk("t1_pops", pop_cnt, 8);
    chk("t1_latency", first_valid - first_rd, 2);
    chk("t1_back_to_back", last_pop - first_pop, 7);
    chk("t1_lasts", last_cnt, 2);

    // stalling consumer
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 100 && pop_cnt < 8; i++) begin
      @(posedge clk);
      #1 m_ready = ~m_ready;
    end
    repeat (5) @(posedge clk);
    chk("t2_pops", pop_cnt, 8);
    chk("t2_leftover", exp_q.size(), 0);

    // en dropped after two reads: burst still completes
    do_reset();
    for (int i = 0; i < 10; i++) push_word(DW'(8'h11 + i));
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 50 && rd_cnt < 2; i++) @(posedge clk);
    #1 en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    repeat (5) @(negedge clk);
    chk("t3_busy", busy, 0);
    chk("t3_reads", rd_cnt, 4);
    chk("t3_pops", pop_cnt, 4);
    chk("t3_last_cnt", last_cnt, 1);
    chk("t3_fifo_left", wr_ptr - rd_ptr, 6);

    // FIFO runs dry mid-burst
    do_reset();
    while (wr_ptr != rd_ptr) rd_ptr++;
    push_word(8'h01); push_word(8'h02);
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 50 && rd_cnt < 2; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t4_reads_dry", rd_cnt, 2);
    chk("t4_gap_valid", m_valid, 0);
    chk("t4_last_cnt_dry", last_cnt, 0);
    @(posedge clk);
    #1 push_word(8'h03); push_word(8'h04);
    wait_pops(4, 50);
    chk("t4_pops", pop_cnt, 4);
    chk("t4_last_cnt", last_cnt, 1);

    // reset with a full buffer
    do_reset();
    for (int i = 0; i < 8; i++) push_word(DW'(8'h40 + i));
    en = 1'b1; m_ready = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", m_valid, 0);
    chk("t5_rd_en", fifo_rd_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_last", m_last, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; m_ready = 1'b1;
    clr_stats();
    @(negedge clk);
    chk("t5_release_rd", fifo_rd_en, 0);
    wait_pops(BL, 50);
    chk("t5_pops", pop_cnt, BL);
    chk("t5_last_cnt", last_cnt, 1);

    // randomized back-pressure and empty flag
    do_reset();
    while (wr_ptr != rd_ptr) rd_ptr++;
    en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      m_ready = ($urandom % 4) != 0;
      hold_empty = ($urandom % 4) == 0;
      if (wr_ptr - rd_ptr < 4 && ($urandom % 2) == 1) push_word(DW'($urandom));
    end
    hold_empty = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 100 && (wr_ptr != rd_ptr || exp_q.size() != 0); i++) @(posedge clk);
    chk("t6_drained", exp_q.size(), 0);
    chk("t6_fifo_empty", wr_ptr - rd_ptr, 0);
    chk("t6_last_rate", last_cnt, pop_cnt / BL);
    chk("t6_traffic", pop_cnt > 1000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
